// File: rtl/led_blink_pkg.sv
// Shared types and constants for the LED blink engine.
package led_blink_pkg;

    typedef enum logic [1:0] {
        OFF,
        SOLID,
        BLINK_ON,
        BLINK_OFF
    } blink_state_t;

    localparam int unsigned SPEED_W = 16;

    localparam logic [SPEED_W-1:0] SPEED_OFF   = 16'h0000;
    localparam logic [SPEED_W-1:0] SPEED_SOLID = 16'hFFFF;

    // Mode a channel enters when its speed word changes; blinking always starts lit.
    function automatic blink_state_t decode_mode(input logic [SPEED_W-1:0] s);
        blink_state_t m;
        if (s == SPEED_OFF) begin
            m = OFF;
        end else if (s == SPEED_SOLID) begin
            m = SOLID;
        end else begin
            m = BLINK_ON;
        end
        return m;
    endfunction

endpackage

// File: rtl/blink_channel.sv
// One LED channel: latches its speed word and blinks with a half-period of that many ticks.
module blink_channel
    import led_blink_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] speed,
    input  logic               tick,
    input  logic               sync,
    output logic               led
);

    blink_state_t       state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SPEED_W-1:0] cnt_q, cnt_d;
    logic               led_q;
    logic               blinking;

    assign blinking = (state_q == BLINK_ON) || (state_q == BLINK_OFF);
    assign led      = led_q;

    // Next state: speed change beats sync, sync beats tick advance.
    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        cnt_d   = cnt_q;
        if (speed != speed_q) begin
            speed_d = speed;
            cnt_d   = '0;
            state_d = decode_mode(speed);
        end else if (sync) begin
            if (blinking) begin
                state_d = BLINK_ON;
                cnt_d   = '0;
            end
        end else if (tick && blinking) begin
            if (cnt_q == speed_q - 16'd1) begin
                state_d = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // State registers; led is registered from the next state so it tracks state_q exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= OFF;
            speed_q <= '0;
            cnt_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            led_q   <= (state_d == SOLID) || (state_d == BLINK_ON);
        end
    end

endmodule

// File: rtl/led_blink_engine.sv
// N-channel LED blink engine with a shared tick prescaler and a phase-align sync pulse.
module led_blink_engine
    import led_blink_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned TICK_HZ     = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SPEED_W*N-1:0] speed,
    input  logic                 sync,
    output logic [N-1:0]         led,
    output logic                 tick
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("led_blink_engine: CLK_FREQ_HZ/TICK_HZ must be at least 2");
    end

    logic [CNT_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;

    assign tick = tick_q;

    // Prescaler wraps at DIV-1; tick is high while the count sits at DIV-1, sync restarts it.
    always_comb begin
        pre_d  = pre_q;
        tick_d = 1'b0;
        if (sync || (pre_q == CNT_MAX)) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + CNT_W'(1);
        end
        tick_d = !sync && (pre_d == CNT_MAX);
    end

    // Prescaler registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        blink_channel u_ch (
            .clk   (clk),
            .reset (reset),
            .speed (speed[SPEED_W*i +: SPEED_W]),
            .tick  (tick_q),
            .sync  (sync),
            .led   (led[i])
        );
    end

endmodule

// File: tb/tb_led_blink_engine.sv
// Bench for led_blink_engine: tick-count reference model plus literal waveform checks.
module tb_led_blink_engine;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [16*N-1:0] speed = '0;
    logic          sync = 1'b0;
    logic [N-1:0]  led;
    logic          tick;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    led_blink_engine #(
        .N           (N),
        .CLK_FREQ_HZ (4),
        .TICK_HZ     (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .speed (speed),
        .sync  (sync),
        .led   (led),
        .tick  (tick)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: cycles since time-base anchor, and per channel the mode,
    // the latched speed and the number of ticks seen since the phase anchor.
    int m_k = 0;
    bit m_tick = 1'b0;
    int m_mode[N];  // 0 off, 1 solid, 2 blink
    int m_s[N];
    int m_n[N];

    function automatic logic [N-1:0] model_led();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = (m_mode[i] == 1) || (m_mode[i] == 2 && ((m_n[i] / m_s[i]) % 2 == 0));
        end
        return r;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            m_mode[i] = 0;
            m_s[i]    = 0;
            m_n[i]    = 0;
        end
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_k    = 0;
                m_tick = 1'b0;
                for (int i = 0; i < N; i++) begin
                    m_mode[i] = 0;
                    m_s[i]    = 0;
                    m_n[i]    = 0;
                end
            end else begin
                bit tick_seen;
                tick_seen = m_tick;
                for (int i = 0; i < N; i++) begin
                    int cur;
                    cur = int'(speed[16*i +: 16]);
                    if (cur != m_s[i]) begin
                        m_s[i]    = cur;
                        m_n[i]    = 0;
                        m_mode[i] = (cur == 0) ? 0 : (cur == 32'h0000_FFFF) ? 1 : 2;
                    end else if (sync && m_mode[i] == 2) begin
                        m_n[i] = 0;
                    end else if (tick_seen && m_mode[i] == 2) begin
                        m_n[i] = m_n[i] + 1;
                    end
                end
                m_k    = sync ? 0 : m_k + 1;
                m_tick = !sync && (m_k % DIV == DIV - 1);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("model_led", 32'(led), 32'(model_led()));
            check("model_tick", 32'(tick), 32'(m_tick));
        end
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_led", 32'(led), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        reset = 1'b1;

        // Tick period 4, first tick on the 4th cycle after release.
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check("tick_phase", 32'(tick), 32'(k % 4 == 3));
        end

        // Solid on, then off, each one cycle after the change.
        @(negedge clk);
        speed[15:0] = 16'hFFFF;
        @(posedge clk);
        #1;
        check("solid_on", 32'(led[0]), 32'd1);
        repeat (5) @(negedge clk);
        speed[15:0] = 16'h0000;
        @(posedge clk);
        #1;
        check("solid_off", 32'(led[0]), 32'd0);

        // Speed 2 after sync: 8 cycles high, 8 low, three periods.
        @(negedge clk);
        speed[31:16] = 16'd2;
        repeat (3) @(negedge clk);
        sync = 1'b1;
        for (int j = 0; j < 48; j++) begin
            @(posedge clk);
            #1;
            sync = 1'b0;
            check("sync_wave", 32'(led[1]), 32'((j / 8) % 2 == 0));
        end

        // Two channels written apart, then aligned by sync.
        @(negedge clk);
        speed[31:16] = 16'd3;
        repeat (5) @(negedge clk);
        speed[47:32] = 16'd3;
        repeat (7) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        repeat (40) begin
            @(negedge clk);
            check("lockstep", 32'(led[1]), 32'(led[2]));
        end

        // Lower the speed mid-ON: stays lit with a fresh counter.
        @(negedge clk);
        speed[63:48] = 16'd5;
        repeat (6) @(negedge clk);
        check("pre_lower", 32'(led[3]), 32'd1);
        speed[63:48] = 16'd1;
        @(posedge clk);
        #1;
        check("lower_on", 32'(led[3]), 32'd1);
        repeat (30) @(negedge clk);

        // Randomized speed writes and sync pulses.
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            sync = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) begin
                int ch;
                int v;
                ch = int'($urandom_range(0, N - 1));
                v  = int'($urandom_range(0, 6));
                case (v)
                    0:       speed[16*ch +: 16] = 16'h0000;
                    1:       speed[16*ch +: 16] = 16'hFFFF;
                    6:       speed[16*ch +: 16] = 16'd7;
                    default: speed[16*ch +: 16] = 16'(v - 1);
                endcase
            end
        end
        @(negedge clk);
        sync = 1'b0;

        // Asynchronous reset mid-blink, then restart.
        speed = {16'hFFFF, 16'h0000, 16'd2, 16'd1};
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset", 32'(led), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_solid", 32'(led[3]), 32'd1);
        check("post_blink", 32'(led[1:0]), 32'd3);
        check("post_off", 32'(led[2]), 32'd0);
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
